// File: rtl/lane_scroller.sv
// Falling-block playfield: LFSR-chosen spawn lanes, one-row scroll per step with a
// stage-shortened step period, and per-lane hit / bad-hit / miss judging on the bottom row.
module lane_scroller #(
  parameter int unsigned LANES          = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TICK_W         = 16,
  parameter int unsigned INIT_PERIOD    = 500,
  parameter int unsigned MIN_PERIOD     = 100,
  parameter int unsigned PERIOD_STEP    = 50,
  parameter int unsigned ROWS_PER_STAGE = 15,
  parameter int unsigned SPAWN_GAP      = 5,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                     system_clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     clear,
  input  logic [LANES-1:0]         hit,
  output logic [LANES*DEPTH-1:0]   channel,
  output logic                     step,
  output logic [7:0]               stage,
  output logic [TICK_W-1:0]        period,
  output logic [LANES-1:0]         hit_ok,
  output logic [LANES-1:0]         hit_bad,
  output logic [LANES-1:0]         miss
);

  localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned GAP_W     = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int unsigned ROWS_W    = (ROWS_PER_STAGE > 1) ? $clog2(ROWS_PER_STAGE) : 1;
  localparam int unsigned FLD_W     = LANES * DEPTH;
  localparam int unsigned DEC_FLOOR = MIN_PERIOD + PERIOD_STEP;
  localparam logic [15:0] SEED_EFF  = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0]        r_lfsr;
  logic [TICK_W-1:0]  r_tick;
  logic [TICK_W-1:0]  r_period;
  logic [GAP_W-1:0]   r_gap;
  logic [ROWS_W-1:0]  r_rows;
  logic [7:0]         r_stage;
  logic [FLD_W-1:0]   r_field;
  logic               r_step;
  logic [LANES-1:0]   r_hit_ok;
  logic [LANES-1:0]   r_hit_bad;
  logic [LANES-1:0]   r_miss;

  logic               w_step;
  logic               w_stage_adv;
  logic               w_spawn;
  logic [LANE_W-1:0]  w_spawn_lane;
  logic [LANES-1:0]   w_bottom;
  logic [LANES-1:0]   w_hit_ok;
  logic [LANES-1:0]   w_hit_bad;
  logic [LANES-1:0]   w_miss;
  logic [FLD_W-1:0]   w_field_nxt;
  logic [TICK_W-1:0]  w_period_dec;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [ROWS_W-1:0]  w_rows_nxt;
  logic [7:0]         w_stage_nxt;

  assign w_step       = run && (r_tick == (r_period - TICK_W'(1)));
  assign w_stage_adv  = w_step && (r_rows == ROWS_W'(ROWS_PER_STAGE - 1));
  assign w_spawn      = (r_gap == '0);
  assign w_spawn_lane = r_lfsr[LANE_W-1:0];
  assign w_gap_nxt    = (r_gap == GAP_W'(SPAWN_GAP - 1)) ? '0 : r_gap + GAP_W'(1);
  assign w_rows_nxt   = w_stage_adv ? '0 : r_rows + ROWS_W'(1);
  assign w_stage_nxt  = (r_stage == 8'hFF) ? r_stage : r_stage + 8'd1;

  // Judge against the pre-step bottom row; a successful hit pre-empts the miss.
  always_comb begin
    w_bottom = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      w_bottom[l] = r_field[l*DEPTH + DEPTH - 1];
    end
  end

  assign w_hit_ok  = {LANES{run}} & hit & w_bottom;
  assign w_hit_bad = {LANES{run}} & hit & ~w_bottom;
  assign w_miss    = {LANES{w_step}} & w_bottom & ~hit;

  // Period shrink, clamped at the floor without wrapping below zero.
  always_comb begin
    w_period_dec = TICK_W'(MIN_PERIOD);
    if (32'(r_period) >= DEC_FLOOR) begin
      w_period_dec = r_period - TICK_W'(PERIOD_STEP);
    end
  end

  always_comb begin
    w_field_nxt = r_field;
    for (int l = 0; l < int'(LANES); l++) begin
      if (w_step) begin
        for (int r = int'(DEPTH) - 1; r > 0; r--) begin
          w_field_nxt[l*DEPTH + r] = r_field[l*DEPTH + r - 1];
        end
        w_field_nxt[l*DEPTH] = w_spawn && (w_spawn_lane == LANE_W'(l));
      end else if (w_hit_ok[l]) begin
        w_field_nxt[l*DEPTH + DEPTH - 1] = 1'b0;
      end
    end
  end

  // Spawn-lane source; free-running, unaffected by run or clear.
  always_ff @(posedge system_clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED_EFF;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge system_clk or negedge rst) begin
    if (!rst) begin
      r_tick    <= '0;
      r_period  <= TICK_W'(INIT_PERIOD);
      r_gap     <= '0;
      r_rows    <= '0;
      r_stage   <= '0;
      r_field   <= '0;
      r_step    <= 1'b0;
      r_hit_ok  <= '0;
      r_hit_bad <= '0;
      r_miss    <= '0;
    end else if (clear) begin
      r_tick    <= '0;
      r_period  <= TICK_W'(INIT_PERIOD);
      r_gap     <= '0;
      r_rows    <= '0;
      r_stage   <= '0;
      r_field   <= '0;
      r_step    <= 1'b0;
      r_hit_ok  <= '0;
      r_hit_bad <= '0;
      r_miss    <= '0;
    end else begin
      r_step    <= w_step;
      r_hit_ok  <= w_hit_ok;
      r_hit_bad <= w_hit_bad;
      r_miss    <= w_miss;
      r_field   <= w_field_nxt;
      if (run) begin
        r_tick <= w_step ? '0 : r_tick + TICK_W'(1);
      end
      if (w_step) begin
        r_gap  <= w_gap_nxt;
        r_rows <= w_rows_nxt;
      end
      if (w_stage_adv) begin
        r_stage  <= w_stage_nxt;
        r_period <= w_period_dec;
      end
    end
  end

  assign channel = r_field;
  assign step    = r_step;
  assign stage   = r_stage;
  assign period  = r_period;
  assign hit_ok  = r_hit_ok;
  assign hit_bad = r_hit_bad;
  assign miss    = r_miss;

endmodule

// File: tb/tb_lane_scroller.sv
// Bench for lane_scroller: array-based playfield model compared every cycle, plus
// hand-computed step timing, stage/period and clear/reset expectations.
`timescale 1ns/1ps
module tb_lane_scroller;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TICK_W = 8;
  localparam int unsigned INIT_P = 4;
  localparam int unsigned MIN_P  = 2;
  localparam int unsigned P_STEP = 1;
  localparam int unsigned RPS    = 3;
  localparam int unsigned GAP    = 2;
  localparam int unsigned FW     = LANES * DEPTH;

  logic              system_clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              clear = 1'b0;
  logic [LANES-1:0]  hit = '0;
  logic [FW-1:0]     channel;
  logic              step;
  logic [7:0]        stage;
  logic [TICK_W-1:0] period;
  logic [LANES-1:0]  hit_ok;
  logic [LANES-1:0]  hit_bad;
  logic [LANES-1:0]  miss;

  lane_scroller #(
    .LANES(LANES), .DEPTH(DEPTH), .TICK_W(TICK_W), .INIT_PERIOD(INIT_P),
    .MIN_PERIOD(MIN_P), .PERIOD_STEP(P_STEP), .ROWS_PER_STAGE(RPS),
    .SPAWN_GAP(GAP), .SEED(16'hACE1)
  ) dut (
    .system_clk(system_clk), .rst(rst), .run(run), .clear(clear), .hit(hit),
    .channel(channel), .step(step), .stage(stage), .period(period),
    .hit_ok(hit_ok), .hit_bad(hit_bad), .miss(miss)
  );

  always #5 system_clk = ~system_clk;

  // Model state: what the outputs must be after the next active edge.
  bit               m_f [LANES][DEPTH];
  int               m_tick, m_period, m_stage, m_steps, m_gap;
  int unsigned      m_lfsr;
  bit               m_step;
  bit [LANES-1:0]   m_ok, m_bad, m_miss;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_f[l, r]) m_f[l][r] = 1'b0;
    m_tick = 0; m_period = INIT_P; m_stage = 0; m_steps = 0; m_gap = 0;
    m_lfsr = 32'hACE1;
    m_step = 1'b0; m_ok = '0; m_bad = '0; m_miss = '0;
  endtask

  task automatic model_edge(input bit r, input bit c, input logic [LANES-1:0] h);
    int sel;
    sel = int'(m_lfsr % LANES);
    m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
    m_step = 1'b0; m_ok = '0; m_bad = '0; m_miss = '0;
    if (c) begin
      foreach (m_f[l, rr]) m_f[l][rr] = 1'b0;
      m_tick = 0; m_period = INIT_P; m_stage = 0; m_steps = 0; m_gap = 0;
      return;
    end
    if (!r) return;
    for (int l = 0; l < int'(LANES); l++) begin
      if (h[l]) begin
        if (m_f[l][DEPTH-1]) begin m_ok[l] = 1'b1; m_f[l][DEPTH-1] = 1'b0; end
        else m_bad[l] = 1'b1;
      end
    end
    if (m_tick == m_period - 1) begin
      m_step = 1'b1;
      for (int l = 0; l < int'(LANES); l++) begin
        m_miss[l] = m_f[l][DEPTH-1];
        for (int rr = int'(DEPTH) - 1; rr > 0; rr--) m_f[l][rr] = m_f[l][rr-1];
        m_f[l][0] = (m_gap == 0) && (l == sel);
      end
      m_tick = 0;
      m_gap = (m_gap + 1) % GAP;
      m_steps++;
      if (m_steps == RPS) begin
        m_steps = 0;
        if (m_stage < 255) m_stage++;
        m_period = (m_period - int'(P_STEP) < int'(MIN_P)) ? int'(MIN_P) : m_period - int'(P_STEP);
      end
    end else begin
      m_tick++;
    end
  endtask

  function automatic logic [FW-1:0] exp_channel();
    logic [FW-1:0] v;
    v = '0;
    foreach (m_f[l, r]) v[l*DEPTH + r] = m_f[l][r];
    return v;
  endfunction

  function automatic int row0_count();
    int n;
    n = 0;
    for (int l = 0; l < int'(LANES); l++) n += int'(channel[l*DEPTH]);
    return n;
  endfunction

  // Single compare point, just after each active edge.
  always @(posedge system_clk) begin
    #1;
    if (cmp_en) begin
      chk("channel", 64'(channel), 64'(exp_channel()));
      chk("step",    64'(step),    64'(m_step));
      chk("stage",   64'(stage),   64'(m_stage));
      chk("period",  64'(period),  64'(m_period));
      chk("hit_ok",  64'(hit_ok),  64'(m_ok));
      chk("hit_bad", 64'(hit_bad), 64'(m_bad));
      chk("miss",    64'(miss),    64'(m_miss));
    end
  end

  task automatic drive(input bit r, input bit c, input logic [LANES-1:0] h);
    run = r; clear = c; hit = h;
    model_edge(r, c, h);
    @(negedge system_clk);
  endtask

  // mode 0: hit a full bottom cell off-step; 1: same on a step edge; 2: hit an empty cell.
  task automatic directed(input int mode);
    bit done;
    bit b;
    bit nx;
    logic [LANES-1:0] h;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      nx = (m_tick == m_period - 1);
      for (int l = 0; l < int'(LANES) && !done; l++) begin
        b = m_f[l][DEPTH-1];
        if ((mode == 0 && b && !nx) || (mode == 1 && b && nx) || (mode == 2 && !b)) begin
          h = '0; h[l] = 1'b1;
          drive(1'b1, 1'b0, h);
          done = 1'b1;
          if (mode == 2) begin
            chk("bad_hit", 64'(hit_bad), 64'(h));
            chk("bad_hit_ok", 64'(hit_ok), 64'd0);
          end else begin
            chk("hit_ok_lane", 64'(hit_ok), 64'(h));
            chk("hit_no_miss", 64'(miss[l]), 64'd0);
            if (mode == 1) chk("hit_on_step", 64'(step), 64'd1);
            else chk("hit_cleared", 64'(channel[l*DEPTH + DEPTH - 1]), 64'd0);
          end
        end
      end
      if (!done) drive(1'b1, 1'b0, '0);
    end
    chk("directed_found", 64'(done), 64'd1);
  endtask

  int exp_cyc   [10] = '{4, 8, 12, 15, 18, 21, 23, 25, 27, 29};
  int exp_stage [10] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
  int exp_per   [10] = '{4, 4, 3, 3, 3, 2, 2, 2, 2, 2};

  initial begin
    int nsteps;
    int nst;
    int npl;
    logic [LANES-1:0] h;
    bit r;
    bit c;
    model_reset();
    #1 rst = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge system_clk);
    chk("rst_channel", 64'(channel), 64'd0);
    chk("rst_period",  64'(period),  64'd4);
    chk("rst_stage",   64'(stage),   64'd0);
    chk("rst_step",    64'(step),    64'd0);
    rst = 1'b1;

    // Step timing, spawn cadence and stage/period progression from run rising.
    nsteps = 0;
    for (int k = 1; k <= 30; k++) begin
      drive(1'b1, 1'b0, '0);
      if (step === 1'b1) begin
        if (nsteps < 10) begin
          chk("step_cycle",  64'(k),      64'(exp_cyc[nsteps]));
          chk("step_stage",  64'(stage),  64'(exp_stage[nsteps]));
          chk("step_period", 64'(period), 64'(exp_per[nsteps]));
          chk("row0_spawn",  64'(row0_count()), 64'((nsteps % 2 == 0) ? 1 : 0));
        end
        nsteps++;
      end
    end
    chk("step_count", 64'(nsteps), 64'd10);

    // Freeze with run low, then clear mid-play.
    drive(1'b1, 1'b0, '0);
    nst = 0; npl = 0;
    repeat (10) begin
      drive(1'b0, 1'b0, LANES'($urandom));
      nst += int'(step);
      npl += int'(|{hit_ok, hit_bad, miss});
    end
    chk("frozen_steps",  64'(nst), 64'd0);
    chk("frozen_pulses", 64'(npl), 64'd0);
    repeat (5) drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, '1);
    chk("clr_channel", 64'(channel), 64'd0);
    chk("clr_period",  64'(period),  64'd4);
    chk("clr_stage",   64'(stage),   64'd0);
    chk("clr_pulses",  64'({step, hit_ok, hit_bad, miss}), 64'd0);

    directed(0);
    repeat (2) drive(1'b1, 1'b0, '0);
    directed(1);
    directed(2);

    // Random play with targeted hits, occasional clears and one async reset.
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(15) != 0);
      c = ($urandom_range(299) == 0);
      for (int l = 0; l < int'(LANES); l++)
        h[l] = m_f[l][DEPTH-1] ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      drive(r, c, h);
      if (k == 1500) begin
        #2 rst = 1'b0;
        model_reset();
        @(negedge system_clk);
        chk("arst_channel", 64'(channel), 64'd0);
        chk("arst_period",  64'(period),  64'd4);
        chk("arst_stage",   64'(stage),   64'd0);
        rst = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_scroller.md
# lane_scroller

Parametrised falling-block playfield generator for the game display. It keeps LANES columns of DEPTH rows, spawns blocks at the top in pseudo-random lanes, and scrolls the field down one row per step. The step period shortens stage by stage. Player hit inputs are judged against the bottom row, and per-lane hit, bad-hit and miss pulses go to the score logic.

## Interface
Parameters:
- LANES, 4, number of lanes; must be a power of two, 2..16
- DEPTH, 16, rows per lane; row 0 = top (spawn), row DEPTH-1 = bottom (judge)
- TICK_W, 16, width of period and tick counter
- INIT_PERIOD, 500, system_clk cycles per step after reset/clear
- MIN_PERIOD, 100, floor for the step period; must be ≥ 2
- PERIOD_STEP, 50, amount the period is reduced at each stage advance
- ROWS_PER_STAGE, 15, steps per stage
- SPAWN_GAP, 5, steps between spawns; must be ≥ 1
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1

Ports:
- system_clk  in  1  sole clock
- rst  in  1  reset: asynchronous, active-low
- run  in  1  level; high = tick counter advances and hits are judged
- clear  in  1  synchronous playfield restart
- hit  in  LANES  per-lane player press, one bit per lane, level-sampled every cycle
- channel  out  LANES*DEPTH  playfield, flattened; bit l*DEPTH+r = lane l, row r
- step  out  1  one-cycle pulse, coincident with each new channel value
- stage  out  8  current stage, saturates at 255
- period  out  TICK_W  current step period
- hit_ok  out  LANES  one-cycle pulse per lane: block removed by hit
- hit_bad  out  LANES  one-cycle pulse per lane: hit with empty bottom cell
- miss  out  LANES  one-cycle pulse per lane: block scrolled out unhit

## Operation
- Reset (rst=0, asynchronous):
  - channel, step, stage, hit_ok, hit_bad, miss, tick counter and gap counter = 0
  - period = INIT_PERIOD
  - LFSR = SEED
- LFSR: 16-bit Galois with taps 16,14,13,11. It advances every cycle out of reset, regardless of run or clear.
- Tick counter: while run=1 it counts 0..period-1. While run=0 it holds, and no step is generated.
- Step (edge where run=1 and tick counter = period-1):
  - Tick counter goes to 0.
  - Each lane shifts down: row r takes the value of row r-1, and the bottom row leaves the field.
  - Row 0 of lane lfsr[log2(LANES)-1:0] gets 1 if the gap counter = 0; every other row 0 gets 0.
  - The gap counter advances 0..SPAWN_GAP-1 and wraps.
- Stage advance: the step counter counts steps. After ROWS_PER_STAGE steps it resets to 0 and:
  - stage increments, saturating at 255;
  - period = max(period - PERIOD_STEP, MIN_PERIOD), computed without underflow.
  - The new period applies from the following interval.
- Hit judging happens on any cycle with run=1. For each lane l with hit[l]=1, inspect the current bottom cell:
  - cell = 1: clear the cell and pulse hit_ok[l];
  - cell = 0: pulse hit_bad[l].
  - hit is level-judged: a held press re-judges every cycle, and the debounce/edge detector upstream is responsible for producing single-cycle hits.
- Miss: on a step, a bottom cell = 1 that was not hit in that same cycle pulses miss[l].
- Hit and step on the same edge: the hit is judged against the pre-step bottom row. A successful hit removes the block, so no miss is raised. The shift then proceeds normally.
- run=0: hits are ignored (no pulses) and the field is frozen.
- clear=1 has priority over run and hit:
  - field, counters, stage and pulses go to 0, and period = INIT_PERIOD;
  - the LFSR keeps running.

## Timing
- All outputs are registered.
- step, hit_ok, hit_bad and miss are high for exactly one cycle, in the cycle after the deciding edge, aligned with the updated channel.
- First step after reset: exactly INIT_PERIOD cycles after run rises, and it spawns a block (gap counter = 0).
- Steady state: steps are exactly period cycles apart.
- A block spawned on step k reaches the bottom row on step k+DEPTH-1 and produces a miss on step k+DEPTH if unhit.
- rst deasserting mid-play returns the block to its reset state. clear on a step edge suppresses that step and its pulses.

## Test plan
- Params LANES=4, DEPTH=4, INIT_PERIOD=4, SPAWN_GAP=2: reset, run=1 -> step pulses at cycles 4, 8, 12…; exactly one row-0 bit set on steps 1, 3, 5…
- ROWS_PER_STAGE=3, MIN_PERIOD=2, PERIOD_STEP=1, INIT_PERIOD=4 -> period reads 4, 3, 2, 2 at stages 0, 1, 2, 3; stage increments every 3rd step.
- Block in lane 2 reaches the bottom; pulse hit[2] one cycle -> hit_ok=4'b0100 next cycle, bottom cell cleared, no miss on the following step.
- Block left unhit -> miss[lane] pulse on the step that shifts it out; hit on an empty lane -> hit_bad pulse only.
- hit[1] coincident with a step edge while lane 1's bottom cell = 1 -> hit_ok[1]=1 and miss[1]=0 in the same cycle.
- Drop run mid-interval for 10 cycles, then pulse clear mid-play -> field frozen and no step while run=0; after clear, all outputs are 0 and period=INIT_PERIOD.
